// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types: data word, RAM handshake state, arbiter state
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick: first pending index at or after ptr, with wrap
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] pending_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_oh_o,
  output logic [IW-1:0]   grant_idx_o,
  output logic            any_o
);

  always_comb begin
    logic [IW-1:0] idx;
    int            j;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = '0;
    j           = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end
      idx = IW'(j);
      if (!any_o && pending_i[idx]) begin
        any_o           = 1'b1;
        grant_idx_o     = idx;
        grant_oh_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_request_arbiter.sv
// rtl/ram_request_arbiter.sv - round-robin owner of the single RAM port with a per-grant beat limit
module ram_request_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAXBEATS = 8,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int BW      = $clog2(MAXBEATS + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] req_ren,
  input  logic [NREQ-1:0] req_wen,
  input  word_t           req_addr  [NREQ],
  input  word_t           req_store [NREQ],
  output logic [NREQ-1:0] req_wait,
  output word_t           req_load,
  output word_t           ramaddr,
  output word_t           ramstore,
  output logic            ramREN,
  output logic            ramWEN,
  input  ramstate_t       ramstate,
  input  word_t           ramload,
  output logic [IW-1:0]   grant_id,
  output logic            busy
);

  arb_state_t      state_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   owner_q;
  logic [BW-1:0]   beats_q;
  logic            busy_q;

  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] others_pending;
  logic [NREQ-1:0] unused_pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [IW-1:0]   next_ptr;
  logic            is_access;
  logic            limit_beat;
  logic            release_own;
  logic            preempt_own;

  assign pending        = req_ren | req_wen;
  assign others_pending = pending & ~(NREQ'(1) << owner_q);
  assign is_access      = (ramstate == ACCESS);
  assign next_ptr       = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  // >= rather than == so an owner already saturated while alone still yields once others arrive
  assign limit_beat  = (beats_q >= BW'(MAXBEATS - 1));
  assign release_own = !pending[owner_q];
  assign preempt_own = is_access && limit_beat && (|others_pending);

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_picker (
    .pending_i   (pending),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (unused_pick_oh),
    .grant_idx_o (pick_idx),
    .any_o       (pick_any)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beats_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            owner_q <= pick_idx;
            beats_q <= '0;
            state_q <= OWN;
            busy_q  <= 1'b1;
          end
        end
        OWN: begin
          if (is_access && (beats_q != BW'(MAXBEATS))) begin
            beats_q <= beats_q + 1'b1;
          end
          if (release_own || preempt_own) begin
            state_q  <= DRAIN;
            rr_ptr_q <= next_ptr;
          end
        end
        DRAIN: begin
          if (ramstate == FREE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // RAM side follows the registered owner, so enables drop with the async reset of state_q
  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    req_wait = '1;
    if (state_q == OWN) begin
      ramaddr           = req_addr[owner_q];
      ramstore          = req_store[owner_q];
      ramWEN            = req_wen[owner_q];
      ramREN            = req_ren[owner_q] & ~req_wen[owner_q];
      req_wait[owner_q] = !is_access;
    end
  end

  assign req_load = ramload;
  assign grant_id = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_ram_request_arbiter.sv
// tb/tb_ram_request_arbiter.sv - directed bench for ram_request_arbiter with immediate assertions
module tb_ram_request_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      nRST;
  logic [3:0] ren, wen, req_wait;
  word_t     addr [4];
  word_t     store [4];
  word_t     req_load, ramaddr, ramstore, ramload;
  logic      ramREN, ramWEN, busy;
  logic [1:0] grant_id;
  ramstate_t ramstate;

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  ram_request_arbiter #(.NREQ(4), .MAXBEATS(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_ren   (ren),
    .req_wen   (wen),
    .req_addr  (addr),
    .req_store (store),
    .req_wait  (req_wait),
    .req_load  (req_load),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramstate  (ramstate),
    .ramload   (ramload),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int order [4];
    logic [3:0] expw;
    int g;
    order = '{1, 3, 1, 3};

    nRST     = 1'b0;
    ren      = 4'b1111;
    wen      = 4'b1111;
    ramstate = FREE;
    ramload  = '0;
    for (int i = 0; i < 4; i++) begin
      addr[i]  = 32'h0000_1000 + 32'(i * 16);
      store[i] = 32'hA000_0000 + 32'(i);
    end

    // reset hold with every request asserted
    repeat (3) tick();
    settle();
    chk("rst_ren", 32'(ramREN), 32'd0);
    chk("rst_wen", 32'(ramWEN), 32'd0);
    chk("rst_wait", 32'(req_wait), 32'hF);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    ren  = 4'b0001;
    wen  = 4'b0000;
    nRST = 1'b1;
    tick();
    settle();
    chk("arb0_ren", 32'(ramREN), 32'd1);
    chk("arb0_addr", ramaddr, 32'h0000_1000);
    chk("arb0_busy", 32'(busy), 32'd1);
    chk("free_wait", 32'(req_wait), 32'hF);
    ramstate = ACCESS;
    ramload  = 32'h55AA_1234;
    settle();
    chk("acc_wait", 32'(req_wait), 32'hE);
    chk("load_bcast", req_load, 32'h55AA_1234);
    tick();
    ren      = 4'b0000;
    ramstate = BUSY;
    tick();
    settle();
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_wait", 32'(req_wait), 32'hF);
    tick();
    settle();
    chk("drain_hold", 32'(busy), 32'd1);
    ramstate = FREE;
    tick();
    settle();
    chk("idle_busy", 32'(busy), 32'd0);

    // contention 1010: single-beat reads, two BUSY cycles then ACCESS
    ren = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      g = order[k];
      tick();
      settle();
      chk("cont_gid", 32'(grant_id), 32'(g));
      chk("cont_ren", 32'(ramREN), 32'd1);
      chk("cont_addr", ramaddr, addr[g]);
      ramstate = BUSY;
      settle();
      chk("cont_busy_wait", 32'(req_wait), 32'hF);
      tick();
      tick();
      settle();
      chk("cont_busy_wait2", 32'(req_wait), 32'hF);
      ramstate = ACCESS;
      settle();
      expw = 4'hF & ~(4'(1) << g);
      chk("cont_acc_wait", 32'(req_wait), 32'(expw));
      tick();
      ren[g]   = 1'b0;
      ramstate = BUSY;
      tick();
      settle();
      chk("cont_drain", 32'(busy), 32'd1);
      chk("cont_drain_ren", 32'(ramREN), 32'd0);
      if (k < 2) ren[g] = 1'b1;
      tick();
      settle();
      chk("cont_drain_hold", 32'(busy), 32'd1);
      ramstate = FREE;
      tick();
      settle();
      chk("cont_idle", 32'(busy), 32'd0);
    end

    // preemption after MAXBEATS beats with req2 waiting
    ren = 4'b0001;
    tick();
    settle();
    chk("pre_gid0", 32'(grant_id), 32'd0);
    ramstate = ACCESS;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk("pre_beat_wait", 32'(req_wait), 32'hE);
      if (i == 2) ren[2] = 1'b1;
      tick();
    end
    settle();
    chk("pre_drain_wait", 32'(req_wait), 32'hF);
    chk("pre_drain_busy", 32'(busy), 32'd1);
    chk("pre_drain_ren", 32'(ramREN), 32'd0);
    tick();
    settle();
    chk("pre_drain_stay", 32'(req_wait), 32'hF);
    ramstate = FREE;
    tick();
    tick();
    settle();
    chk("pre_gid2", 32'(grant_id), 32'd2);
    chk("pre_addr2", ramaddr, addr[2]);
    ramstate = ACCESS;
    settle();
    chk("pre_wait2", 32'(req_wait), 32'hB);
    tick();
    ren[2]   = 1'b0;
    ramstate = FREE;
    tick();
    tick();
    tick();
    settle();
    chk("pre_resume_gid", 32'(grant_id), 32'd0);
    chk("pre_resume_ren", 32'(ramREN), 32'd1);
    ren = 4'b0000;
    tick();
    tick();
    settle();
    chk("pre_idle", 32'(busy), 32'd0);

    // lone requester: beat limit ignored for 20 beats
    ren = 4'b0010;
    tick();
    ramstate = ACCESS;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk("solo_beat_wait", 32'(req_wait), 32'hD);
      tick();
    end
    settle();
    chk("solo_gid", 32'(grant_id), 32'd1);
    chk("solo_busy", 32'(busy), 32'd1);
    ren      = 4'b0000;
    ramstate = FREE;
    tick();
    tick();

    // simultaneous ren+wen on requester 2
    addr[2]  = 32'h0000_0100;
    store[2] = 32'hDEAD_BEEF;
    ren      = 4'b0100;
    wen      = 4'b0100;
    tick();
    settle();
    chk("rw_gid", 32'(grant_id), 32'd2);
    chk("rw_wen", 32'(ramWEN), 32'd1);
    chk("rw_ren", 32'(ramREN), 32'd0);
    chk("rw_store", ramstore, 32'hDEAD_BEEF);
    chk("rw_addr", ramaddr, 32'h0000_0100);

    // ERROR behaves as BUSY
    ramstate = ERROR;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("err_wait", 32'(req_wait), 32'hF);
      tick();
    end
    ramstate = ACCESS;
    settle();
    chk("err_then_acc", 32'(req_wait), 32'hB);

    // asynchronous reset in the middle of OWN
    nRST = 1'b0;
    settle();
    chk("arst_wen", 32'(ramWEN), 32'd0);
    chk("arst_ren", 32'(ramREN), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_gid", 32'(grant_id), 32'd0);
    chk("arst_wait", 32'(req_wait), 32'hF);
    ren  = 4'b0000;
    wen  = 4'b0000;
    nRST = 1'b1;
    tick();
    settle();
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
